// File: rtl/bytebeat_pkg.sv
`default_nettype none
// ============================================================================
// bytebeat_pkg
// Shared widths, voice encoding, one-hot select constants and FSM states.
// Revision: 1.0
// ============================================================================
package bytebeat_pkg;

    localparam int T_WIDTH   = 19;
    localparam int S_WIDTH   = 8;
    localparam int CAP_WIDTH = 4;

    typedef enum logic [1:0] {
        VOICE_A    = 2'd0,
        VOICE_B    = 2'd1,
        VOICE_C    = 2'd2,
        VOICE_MUTE = 2'd3
    } voice_e;

    localparam logic [2:0] SEL_A    = 3'b001;
    localparam logic [2:0] SEL_B    = 3'b010;
    localparam logic [2:0] SEL_C    = 3'b100;
    localparam logic [2:0] SEL_NONE = 3'b000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Mute maps to no select line, so the mux returns zero.
    function automatic logic [2:0] voice_decode(input logic [1:0] req);
        logic [2:0] sel;
        case (voice_e'(req))
            VOICE_A: sel = SEL_A;
            VOICE_B: sel = SEL_B;
            VOICE_C: sel = SEL_C;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bytebeat_sequencer_if.sv
`default_nettype none
// ============================================================================
// bytebeat_sequencer_if
// Control, time-index and sample bus between sequencer and its surroundings.
// Revision: 1.0
// ============================================================================
interface bytebeat_sequencer_if #(
    parameter int T_WIDTH   = bytebeat_pkg::T_WIDTH,
    parameter int S_WIDTH   = bytebeat_pkg::S_WIDTH,
    parameter int DIV_WIDTH = 16
);
    logic                 enable;
    logic [DIV_WIDTH-1:0] div;
    logic [1:0]           voice_req;
    logic [S_WIDTH-1:0]   sample_in;
    logic [T_WIDTH-1:0]   t;
    logic [2:0]           sel;
    logic [S_WIDTH-1:0]   sample;
    logic                 sample_valid;
    logic                 t_wrap;

    modport master (
        input  enable, div, voice_req, sample_in,
        output t, sel, sample, sample_valid, t_wrap
    );

    modport slave (
        output enable, div, voice_req, sample_in,
        input  t, sel, sample, sample_valid, t_wrap
    );
endinterface
`default_nettype wire

// File: rtl/bytebeat_prescaler.sv
`default_nettype none
// ============================================================================
// bytebeat_prescaler
// Loadable down-counter; tick when it reaches zero while running.
// Revision: 1.0
// ============================================================================
module bytebeat_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_run,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);
    logic [DIV_WIDTH-1:0] count_q, count_d;

    assign o_tick = i_run && (count_q == '0);

    // Anything other than load/run parks the counter at zero.
    always_comb begin
        count_d = '0;
        if (i_load) begin
            count_d = i_div;
        end else if (i_run) begin
            count_d = o_tick ? i_div : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bytebeat_sequencer.sv
`default_nettype none
// ============================================================================
// bytebeat_sequencer
// Time-index generator, voice select driver and delayed sample capture.
// Revision: 1.0
// ============================================================================
module bytebeat_sequencer #(
    parameter int T_WIDTH       = bytebeat_pkg::T_WIDTH,
    parameter int S_WIDTH       = bytebeat_pkg::S_WIDTH,
    parameter int DIV_WIDTH     = 16,
    parameter int CAPTURE_DELAY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bytebeat_sequencer_if.master  bus
);
    import bytebeat_pkg::*;

    localparam logic [CAP_WIDTH-1:0] C_CAP_LOAD = CAP_WIDTH'(CAPTURE_DELAY);

    state_e                 state_q, state_d;
    logic [T_WIDTH-1:0]     t_q, t_d;
    logic [2:0]             sel_q, sel_d;
    logic [S_WIDTH-1:0]     sample_q, sample_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   t_wrap_q, t_wrap_d;
    logic [CAP_WIDTH-1:0]   cap_q, cap_d;
    logic                   w_load, w_run, w_tick;

    assign w_load = (state_q == ST_IDLE) && bus.enable;
    assign w_run  = (state_q == ST_RUN) && bus.enable;

    bytebeat_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_run  (w_run),
        .i_div  (bus.div),
        .o_tick (w_tick)
    );

    // cap_q == 0 means no capture pending; the sample is taken when it hits 1.
    always_comb begin
        state_d        = state_q;
        t_d            = t_q;
        sel_d          = sel_q;
        sample_d       = sample_q;
        cap_d          = cap_q;
        sample_valid_d = 1'b0;
        t_wrap_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                    cap_d   = '0;
                end else begin
                    if (cap_q == CAP_WIDTH'(1)) begin
                        sample_d       = bus.sample_in;
                        sample_valid_d = 1'b1;
                    end
                    if (cap_q != '0) begin
                        cap_d = cap_q - 1'b1;
                    end
                    // A tick restarts any pending capture after letting a due one fire.
                    if (w_tick) begin
                        t_d      = t_q + 1'b1;
                        t_wrap_d = &t_q;
                        sel_d    = voice_decode(bus.voice_req);
                        cap_d    = C_CAP_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            t_q            <= '0;
            sel_q          <= SEL_A;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            t_wrap_q       <= 1'b0;
            cap_q          <= '0;
        end else begin
            state_q        <= state_d;
            t_q            <= t_d;
            sel_q          <= sel_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            t_wrap_q       <= t_wrap_d;
            cap_q          <= cap_d;
        end
    end

    assign bus.t            = t_q;
    assign bus.sel          = sel_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.t_wrap       = t_wrap_q;
endmodule
`default_nettype wire
